// File: rtl/zap_wb_burst_responder.sv
// Wishbone B3 slave over a word-addressed SRAM, answering classic and incrementing-burst
// cycles with registered ACK/ERR/data, byte-lane writes and optional initial wait states.
module zap_wb_burst_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic [31:0] i_wb_adr,
  input  logic        i_wb_wen,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_dat,
  input  logic [2:0]  i_wb_cti,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [2:0]  o_dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Handshake: a beat completes on a rising edge where cyc & stb & (ack | err) are all high.
  // ACK seen while stb is low is not a beat and changes nothing.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACT  = 3'd2,
    ST_GAP  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            wen_q, wen_d;
  logic [31:0]     dat_q, dat_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            mem_we;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   adr_idx;
  logic [AW-1:0]   idx_inc;
  logic            req;
  logic            beat;
  logic            cti_legal;
  logic            cti_incr;
  logic            unused_adr;

  assign adr_idx    = i_wb_adr[AW+1:2];
  assign idx_inc    = idx_q + AW'(1);
  assign req        = i_wb_cyc & i_wb_stb;
  assign beat       = req & ack_q;
  assign cti_incr   = (i_wb_cti == 3'b010);
  assign cti_legal  = (i_wb_cti == 3'b000) | cti_incr | (i_wb_cti == 3'b111);
  assign unused_adr = ^{i_wb_adr[31:AW+2], i_wb_adr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wen_d   = wen_q;
    dat_d   = dat_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d = adr_idx;
          wen_d = i_wb_wen;
          if (!cti_legal) begin
            state_d = ST_ERR;
          end else begin
            if (!i_wb_wen) dat_d = mem[adr_idx];
            if (WAIT_STATES > 0) begin
              cnt_d   = 4'(WAIT_STATES);
              state_d = ST_WAIT;
            end else begin
              state_d = ST_ACT;
            end
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!i_wb_cyc) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = ST_ACT;
        end
      end
      ST_ACT: begin
        if (!i_wb_cyc) begin
          state_d = ST_IDLE;
        end else if (beat) begin
          mem_we = wen_q;
          // Any cti other than incrementing ends the burst after this beat.
          if (cti_incr) begin
            idx_d = idx_inc;
            if (!wen_q) dat_d = mem[idx_inc];
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_GAP;
      default: state_d = ST_IDLE;
    endcase
    ack_d = (state_d == ST_ACT);
    err_d = (state_d == ST_ERR);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wen_q   <= 1'b0;
      dat_q   <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wen_q   <= wen_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wb_sel[b]) mem[idx_q][8*b +: 8] <= i_wb_dat[8*b +: 8];
      end
    end
  end

  assign o_wb_dat    = dat_q;
  assign o_wb_ack    = ack_q;
  assign o_wb_err    = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_zap_wb_burst_responder.sv
// Directed bench for zap_wb_burst_responder: one instance without wait states, one with two.
module tb_zap_wb_burst_responder;

  logic        clk;
  logic        rst_n;
  logic        cyc, stb, wen, use2;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [2:0]  cti;

  logic [31:0] dat0, dat2, dat_o;
  logic        ack0, ack2, ack_o;
  logic        err0, err2, err_o;
  logic [2:0]  st0, st2, st_o;
  logic        cyc0, cyc2;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] IDLE_CODE = 3'd0;

  assign cyc0  = use2 ? 1'b0 : cyc;
  assign cyc2  = use2 ? cyc : 1'b0;
  assign dat_o = use2 ? dat2 : dat0;
  assign ack_o = use2 ? ack2 : ack0;
  assign err_o = use2 ? err2 : err0;
  assign st_o  = use2 ? st2  : st0;

  zap_wb_burst_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc0), .i_wb_stb(stb),
    .i_wb_adr(adr), .i_wb_wen(wen), .i_wb_sel(sel), .i_wb_dat(wdat), .i_wb_cti(cti),
    .o_wb_dat(dat0), .o_wb_ack(ack0), .o_wb_err(err0), .o_dbg_state(st0)
  );

  zap_wb_burst_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc2), .i_wb_stb(stb),
    .i_wb_adr(adr), .i_wb_wen(wen), .i_wb_sel(sel), .i_wb_dat(wdat), .i_wb_cti(cti),
    .o_wb_dat(dat2), .o_wb_ack(ack2), .o_wb_err(err2), .o_dbg_state(st2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic wait_ack(output int lat);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack_o || err_o) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
    chk("ack_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic classic(input bit w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] rd, output int lat);
    cyc = 1'b1; stb = 1'b1; wen = w; adr = a; sel = s; wdat = d; cti = 3'b000;
    wait_ack(lat);
    rd = dat_o;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; wen = 1'b0;
    chk("gap_ack_low", {31'd0, ack_o}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic burst(input bit w, input logic [31:0] a, input logic [31:0] wd [4],
                       output logic [31:0] rd [4], output int nack, output int lat);
    cyc = 1'b1; stb = 1'b1; wen = w; adr = a; sel = 4'hF; wdat = wd[0]; cti = 3'b010;
    wait_ack(lat);
    nack = 0;
    for (int k = 0; k < 4; k++) begin
      if (ack_o) nack++;
      rd[k] = dat_o;
      @(posedge clk); #1;
      if (k < 3) begin
        wdat = wd[k+1];
        cti  = (k == 2) ? 3'b111 : 3'b010;
      end
    end
    chk("burst_tail_ack", {31'd0, ack_o}, 32'd0);
    cyc = 1'b0; stb = 1'b0; wen = 1'b0; cti = 3'b000;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  int          lat, nack;
  logic [31:0] wd [4];
  logic [31:0] rb [4];

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; wen = 1'b0; use2 = 1'b0;
    adr = '0; wdat = '0; sel = '0; cti = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack0", {31'd0, ack0}, 32'd0);
    chk("rst_err0", {31'd0, err0}, 32'd0);
    chk("rst_dat0", dat0, 32'd0);
    chk("rst_state0", {29'd0, st0}, {29'd0, IDLE_CODE});
    chk("rst_ack2", {31'd0, ack2}, 32'd0);
    chk("rst_dat2", dat2, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // classic write/read
    classic(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, lat);
    chk("cw_lat", lat, 32'd1);
    classic(1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
    chk("cr_lat", lat, 32'd1);
    chk("cr_data", rd, 32'hDEADBEEF);
    classic(1'b0, 32'h410, 4'hF, 32'h0, rd, lat);
    chk("alias_data", rd, 32'hDEADBEEF);

    // byte lanes
    classic(1'b1, 32'h20, 4'hF, 32'h11223344, rd, lat);
    classic(1'b1, 32'h20, 4'b0010, 32'h0000AB00, rd, lat);
    classic(1'b0, 32'h20, 4'hF, 32'h0, rd, lat);
    chk("lane_data", rd, 32'h1122AB44);

    // 4-beat burst write then read
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    burst(1'b1, 32'h40, wd, rb, nack, lat);
    chk("bw_nack", nack, 32'd4);
    burst(1'b0, 32'h40, wd, rb, nack, lat);
    chk("br_nack", nack, 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("br_d%0d", k), rb[k], 32'hA0 + k);

    // wrap from index 255 to 0
    classic(1'b1, 32'h3F8, 4'hF, 32'hC0DE00FE, rd, lat);
    classic(1'b1, 32'h3FC, 4'hF, 32'hC0DE00FF, rd, lat);
    classic(1'b1, 32'h000, 4'hF, 32'hC0DE0000, rd, lat);
    classic(1'b1, 32'h004, 4'hF, 32'hC0DE0001, rd, lat);
    burst(1'b0, 32'h3F8, wd, rb, nack, lat);
    chk("wrap_d0", rb[0], 32'hC0DE00FE);
    chk("wrap_d1", rb[1], 32'hC0DE00FF);
    chk("wrap_d2", rb[2], 32'hC0DE0000);
    chk("wrap_d3", rb[3], 32'hC0DE0001);

    // wait states and error on the second instance
    use2 = 1'b1;
    @(posedge clk); #1;
    classic(1'b1, 32'h10, 4'hF, 32'h13572468, rd, lat);
    chk("ws_w_lat", lat, 32'd3);
    classic(1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
    chk("ws_r_lat", lat, 32'd3);
    chk("ws_r_data", rd, 32'h13572468);
    wd[0] = 32'hC0; wd[1] = 32'hC1; wd[2] = 32'hC2; wd[3] = 32'hC3;
    burst(1'b1, 32'h40, wd, rb, nack, lat);
    chk("ws_bw_lat", lat, 32'd3);
    chk("ws_bw_nack", nack, 32'd4);
    burst(1'b0, 32'h40, wd, rb, nack, lat);
    chk("ws_br_d3", rb[3], 32'hC3);

    cyc = 1'b1; stb = 1'b1; wen = 1'b1; adr = 32'h10; sel = 4'hF; wdat = 32'hFFFFFFFF; cti = 3'b011;
    @(posedge clk); #1;
    chk("err_high", {31'd0, err_o}, 32'd1);
    chk("err_no_ack", {31'd0, ack_o}, 32'd0);
    @(posedge clk); #1;
    chk("err_one_cycle", {31'd0, err_o}, 32'd0);
    chk("err_gap_ack", {31'd0, ack_o}, 32'd0);
    cyc = 1'b0; stb = 1'b0; wen = 1'b0; cti = 3'b000;
    @(posedge clk); #1;
    classic(1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
    chk("err_mem_kept", rd, 32'h13572468);

    // reset during beat 2 of a burst write
    use2 = 1'b0;
    @(posedge clk); #1;
    classic(1'b1, 32'h88, 4'hF, 32'h55555555, rd, lat);
    classic(1'b1, 32'h8C, 4'hF, 32'h55555555, rd, lat);
    cyc = 1'b1; stb = 1'b1; wen = 1'b1; adr = 32'h80; sel = 4'hF; wdat = 32'hB0; cti = 3'b010;
    wait_ack(lat);
    @(posedge clk); #1;
    wdat = 32'hB1;
    @(posedge clk); #1;
    wdat = 32'hB2;
    chk("pre_rst_ack", {31'd0, ack_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_async_err", {31'd0, err_o}, 32'd0);
    cyc = 1'b0; stb = 1'b0; wen = 1'b0; cti = 3'b000;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_state", {29'd0, st_o}, {29'd0, IDLE_CODE});
    chk("post_rst_ack", {31'd0, ack_o}, 32'd0);
    classic(1'b0, 32'h80, 4'hF, 32'h0, rd, lat);
    chk("rst_beat0", rd, 32'hB0);
    classic(1'b0, 32'h84, 4'hF, 32'h0, rd, lat);
    chk("rst_beat1", rd, 32'hB1);
    classic(1'b0, 32'h88, 4'hF, 32'h0, rd, lat);
    chk("rst_beat2", rd, 32'h55555555);
    classic(1'b0, 32'h8C, 4'hF, 32'h0, rd, lat);
    chk("rst_beat3", rd, 32'h55555555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zap_wb_burst_responder.md
# zap_wb_burst_responder

Wishbone B3 slave with an internal word-addressed SRAM. It is the responder end of the registered-feedback classic and incrementing-burst cycles (CTI 000/010/111) issued by the cache clean and fill paths. Its main use is as the memory model and on-chip scratch memory that terminates the cache's 4-beat line write-backs and line fills. It returns registered ACK/ERR and read data, and supports byte-lane writes and programmable initial wait states.

## Interface
- DEPTH_WORDS, 256, memory depth in 32-bit words; power of two, ≥ 4
- WAIT_STATES, 0, extra cycles inserted before the first ACK of every Wishbone cycle; range 0–15
- i_clk  input  1  clock, rising edge
- i_reset_n  input  1  reset, asynchronous assert, active-low
- i_wb_cyc  input  1  cycle valid
- i_wb_stb  input  1  strobe
- i_wb_adr  input  32  byte address; bits [1:0] ignored
- i_wb_wen  input  1  1 = write, 0 = read
- i_wb_sel  input  4  byte-lane enables for writes
- i_wb_dat  input  32  write data
- i_wb_cti  input  3  000 classic, 010 incrementing burst, 111 end-of-burst
- o_wb_dat  output  32  read data, registered
- o_wb_ack  output  1  transfer acknowledge, registered
- o_wb_err  output  1  error response, registered

## Operation
- Word index = i_wb_adr[$clog2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so the memory aliases across the address space.
- **Reset values:**
  - o_wb_ack = 0, o_wb_err = 0, o_wb_dat = 0
  - state = IDLE, wait counter = 0, index register = 0
  - SRAM contents are not reset.
- **Handshake:** a beat completes at a rising edge where i_wb_cyc & i_wb_stb & (o_wb_ack | o_wb_err) = 1. An ACK seen with stb low is not a beat and has no effect.
- **States:**
  - IDLE:
    - On cyc & stb, latch the index and wen and sample cti.
    - If cti ∈ {001, 011, 100, 101, 110}, go to ERR.
    - Otherwise, if WAIT_STATES > 0, load the counter and go to WAIT; else go to ACT.
    - For reads, o_wb_dat is loaded from mem[index] on the same edge.
  - WAIT:
    - Decrement the counter; go to ACT when it reaches 1.
    - If cyc drops, go to IDLE.
  - ACT:
    - o_wb_ack = 1.
    - On a beat edge with wen = 1, write the lanes of i_wb_dat enabled by i_wb_sel into mem[index].
    - On a beat edge with cti = 010:
      - index ← (index + 1) mod DEPTH_WORDS.
      - For reads, o_wb_dat ← mem[index + 1], so the next beat's data is ready in the following cycle.
      - o_wb_ack stays 1.
    - On a beat edge with cti ∈ {000, 111}: o_wb_ack ← 0 and go to GAP.
    - If cyc drops: o_wb_ack ← 0 and go to IDLE with no write.
  - GAP: one cycle with ACK low, which prevents a double ACK to a master that holds stb. Then go to IDLE.
  - ERR: o_wb_err = 1 for one cycle, no memory write, then go to GAP.
- **Burst addressing:** the index is advanced internally; i_wb_adr is sampled only in IDLE. A burst wraps from DEPTH_WORDS−1 to 0.
- **Mid-burst cti change:** a change 010 → 000 is treated like 111 (terminate after that beat).
- **Reset mid-operation:** ACK and ERR clear immediately (asynchronously). Beats completed before reset remain in memory.

## Timing
- **Classic, WAIT_STATES = 0:**
  - stb first sampled at edge E0.
  - ACK is high in the cycle after E0 (beat at E1).
  - ACK is low for at least one cycle after E1.
  - Minimum classic throughput is one transfer per 3 cycles.
- **Wait states:** the first ACK is delayed by WAIT_STATES cycles. Later burst beats have no extra wait.
- **Burst:** N beats complete in N consecutive cycles after the first ACK, provided stb stays high.
- **Read data:** o_wb_dat is valid in every cycle where o_wb_ack = 1. It holds its value when no beat occurs.
- **Simultaneous write and read of one word:** a write beat followed by a classic read of the same word returns the new data.

## Test plan
- **Classic write/read:** classic write of 0xDEADBEEF, sel = 1111, to 0x10, then classic read of 0x10. Required: o_wb_dat = 0xDEADBEEF, ACK one cycle wide one cycle after stb, ACK low in the GAP cycle.
- **Byte-lane write:** word at 0x20 holds 0x11223344; write 0x0000AB00 with sel = 0010. Required: read returns 0x1122AB44.
- **4-beat burst write:** at 0x40, cti 010, 010, 010, 111, data 0xA0–0xA3. Required: ACK high for exactly 4 consecutive cycles then low. A following 4-beat burst read returns 0xA0, 0xA1, 0xA2, 0xA3 on consecutive ACK cycles.
- **Burst wrap:** DEPTH_WORDS = 256, 4-beat burst read starting at 0x3F8. Required: returns words at indices 254, 255, 0, 1.
- **Wait states and error:** WAIT_STATES = 2, classic read. Required: ACK in the 3rd cycle after stb. Then a cycle with cti = 011. Required: o_wb_err for one cycle, no ACK, memory unchanged.
- **Reset mid-burst:** i_reset_n pulsed low during beat 2 of a 4-beat write. Required: ACK = 0 immediately, state = IDLE after release, beats 0–1 retained, beats 2–3 unwritten.
